// File: rtl/therm_stream_decoder_pkg.sv
// Shared constants and helpers for the thermometer stream decoder and its checker.
package therm_stream_decoder_pkg;

  localparam int DEFAULT_W  = 16;
  localparam int DEFAULT_CW = 8;

  // Width needed to hold a level in 0..w inclusive.
  function automatic int code_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/therm_stream_decoder_therm_check.sv
// Combinational thermometer legality check and popcount, shared by single- and multi-channel decoders.
module therm_check
  import therm_stream_decoder_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0]         word,
  output logic                 legal,
  output logic [code_w(W)-1:0] count
);

  localparam int CODE_W = code_w(W);

  logic [W-2:0] diff;

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CODE_W'(word[i]);
    end
  end

  // A legal word has at most one adjacent-bit transition, and any transition must start from a 1 at bit 0.
  assign diff  = word[W-1:1] ^ word[W-2:0];
  assign legal = (diff == '0) ||
                 (((diff & (diff - (W-1)'(1))) == '0) && word[0]);

endmodule

// File: rtl/therm_stream_decoder.sv
// Two-stage back-pressurable thermometer-to-binary decoder with optional bubble repair and error counting.
module therm_stream_decoder
  import therm_stream_decoder_pkg::*;
#(
  parameter int W          = DEFAULT_W,
  parameter int BUBBLE_FIX = 0,
  parameter int CW         = DEFAULT_CW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [code_w(W)-1:0] out_code,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [CW-1:0]        err_cnt
);

  localparam int          CODE_W  = code_w(W);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic              s1_valid;
  logic              s2_valid;
  logic              s1_adv;
  logic              s2_adv;
  logic [W-1:0]      corr;
  logic [W-1:0]      s1_data;
  logic              chk_legal;
  logic [CODE_W-1:0] chk_count;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Bubble repair votes over raw neighbours, with an implied 1 below bit 0 and 0 above the MSB.
  generate
    if (BUBBLE_FIX != 0) begin : g_fix
      logic [W+1:0] ext;
      assign ext = {1'b0, in_data, 1'b1};
      for (genvar i = 0; i < W; i++) begin : g_bit
        assign corr[i] = maj3(ext[i], ext[i+1], ext[i+2]);
      end
    end else begin : g_strict
      assign corr = in_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (s1_adv && in_valid) begin
      s1_data <= corr;
    end
  end

  therm_check #(
    .W(W)
  ) u_check (
    .word  (s1_data),
    .legal (chk_legal),
    .count (chk_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_code <= '0;
      out_err  <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_code <= chk_count;
          out_err  <= !chk_legal;
        end
      end
    end
  end

  // A clear arriving alongside an errored delivery takes priority over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + CW'(1);
    end
  end

endmodule

// File: doc/therm_stream_decoder.md
Name: therm_stream_decoder

Overview:
- Pipelined, back-pressurable thermometer-code validator and encoder for flash-ADC-style data paths.
- Accepts one W-bit thermometer word per handshake, with ones filled from the LSB.
- Optionally repairs single-bit bubbles.
- Emits the binary level, a per-word error flag and a saturating error count.
- Sits between the comparator capture register and downstream binary-domain logic.

Parameters:
- W, 16, input word width in bits (W >= 3).
- BUBBLE_FIX, 0, 0 = strict checking; 1 = 3-input majority bubble correction before checking.
- CW, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  W  thermometer word.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_code  out  $clog2(W+1)  number of ones in the (corrected) word, 0..W.
- out_err  out  1  the (corrected) word is not a legal thermometer code.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  CW  saturating count of errored words delivered.

Behaviour:
- Reset is asynchronous and active-high. While rst=1: both stage-valid bits = 0, out_valid=0, out_code=0, out_err=0, err_cnt=0; in_ready=1 one cycle after reset deassertion.
- Legal code: form 0…01…1 (LSB side ones), including all-zero (0) and all-one (W).
  - Equivalently: at most one adjacent-bit transition, and if one exists, bit0=1.
- Correction (BUBBLE_FIX=1):
  - c[i] = maj(r[i-1], r[i], r[i+1]), using raw neighbours, with r[-1]=1 and r[W]=0.
  - BUBBLE_FIX=0: c = r.
- Stage 1 registers c. Stage 2 registers popcount(c) into out_code and the illegal-code flag into out_err.
  - Latency: 2 cycles from input handshake to out_valid with no stall.
  - Throughput: 1 word/cycle.
- Handshake (valid/ready, per stage):
  - s2 advances when !s2_valid || out_ready.
  - s1 advances when !s1_valid || s2 advance.
  - in_ready = s1 advance. in_ready is combinational from out_ready; no combinational path from in_valid to in_ready.
  - Data is held stable while out_valid && !out_ready.
  - No word is dropped or duplicated under any stall pattern.
- out_code / out_err are reported even for errored words; the code is the popcount, not a correction.
- err_cnt:
  - Increments when out_valid && out_ready && out_err.
  - Saturates at 2^CW-1 (no wrap).
  - err_clr in the same cycle as an increment: the clear wins and the result is 0.
- Stage data registers need no reset; the valid bits and outputs listed above do.
- Reset mid-stream: all in-flight words are discarded, and no out_valid appears until new input arrives.

Decomposition:
- Shared header of localparams: CODE_W = $clog2(W+1).
- One natural sub-module, therm_check: purely combinational, W-parametrised.
  - Outputs: legality flag and popcount.
  - Reused by future multi-channel variants.
- Pipeline, handshake and counter stay in the top module.

Test Plan (W=8, out_ready=1 unless stated):
- Strict mode, inputs 0x00, 0x0F, 0xFF back-to-back -> out_code 0, 4, 8, out_err=0, on consecutive cycles 2 cycles after each accept.
- Strict mode, 0x0B -> out_code 3, out_err=1, err_cnt 0->1; 0x80 -> code 1, err=1; 0xFE -> code 7, err=1.
- BUBBLE_FIX=1, 0x0B -> corrected 0x07, out_code 3, out_err=0; 0x1D -> corrected 0x1F, code 5, err=0.
- Backpressure: stream 0x01, 0x03, 0x07, 0x0F with out_ready low for 3 cycles mid-stream.
  - in_ready drops once both stages are full.
  - Outputs are exactly 1, 2, 3, 4 in order; out_code holds steady while stalled.
- Counter with CW=2: five errored words -> err_cnt 1, 2, 3, 3, 3.
  - err_clr coincident with an errored accept -> err_cnt=0.
- Reset asserted asynchronously with two words in flight -> out_valid drops immediately, err_cnt=0.
  - No stale word emerges after release; the next input 0x03 yields code 2 after 2 cycles.
